// File: rtl/div_sequencer.sv
// div_sequencer
//   Request queue and issue controller in front of the shared divider.
//   Requesters post tagged divide jobs into a small FIFO. The controller
//   issues one job at a time to the divider, keeps the operands stable
//   while it runs and returns quotient/remainder with the job's tag through
//   a valid/ready result slot. A job whose divisor is zero never reaches the
//   divider: it completes locally with quotient all-ones and remainder equal
//   to the dividend.
//
// Ports
//   ctl_clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_signed     dividend, divisor, signed-division select
//   req_tag                      requester id, returned with the result
//   res_valid/res_ready          result handshake
//   res_q, res_r, res_tag        quotient, remainder, tag of the job
//   res_dbz                      result produced by the divide-by-zero bypass
//   busy                         FIFO non-empty or a job still owned here
//   div_a, div_b, div_signed_cal operands driven to the divider
//   div_trigger                  one-cycle start pulse to the divider
//   div_ready, div_done          divider status
//   div_q, div_r                 divider results
module div_sequencer #(
    parameter int C_WIDTH    = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ctl_clk,
    input  logic                 reset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [C_WIDTH-1:0]   req_a,
    input  logic [C_WIDTH-1:0]   req_b,
    input  logic                 req_signed,
    input  logic [TAG_WIDTH-1:0] req_tag,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [C_WIDTH-1:0]   res_q,
    output logic [C_WIDTH-1:0]   res_r,
    output logic [TAG_WIDTH-1:0] res_tag,
    output logic                 res_dbz,

    output logic                 busy,

    output logic [C_WIDTH-1:0]   div_a,
    output logic [C_WIDTH-1:0]   div_b,
    output logic                 div_signed_cal,
    output logic                 div_trigger,
    input  logic                 div_ready,
    input  logic                 div_done,
    input  logic [C_WIDTH-1:0]   div_q,
    input  logic [C_WIDTH-1:0]   div_r
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Quotient reported for a zero divisor.
    function automatic logic [C_WIDTH-1:0] dbz_quotient();
        return '1;
    endfunction

    // ---------------------------------------------------------------- request FIFO
    logic [C_WIDTH-1:0]   fifo_a   [FIFO_DEPTH];
    logic [C_WIDTH-1:0]   fifo_b   [FIFO_DEPTH];
    logic                 fifo_s   [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [C_WIDTH-1:0]   head_a;
    logic [C_WIDTH-1:0]   head_b;
    logic                 head_signed;
    logic [TAG_WIDTH-1:0] head_tag;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign req_ready = !full && !reset;
    assign push      = req_valid && req_ready;

    assign head_a      = fifo_a[rd_ptr];
    assign head_b      = fifo_b[rd_ptr];
    assign head_signed = fifo_s[rd_ptr];
    assign head_tag    = fifo_tag[rd_ptr];

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= req_a;
            fifo_b[wr_ptr]   <= req_b;
            fifo_s[wr_ptr]   <= req_signed;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    // ---------------------------------------------------------------- issue control
    state_t state;
    state_t state_nxt;
    logic   armed;
    logic   slot_free;
    logic   issue;
    logic   take_dbz;
    logic   take_div;
    logic   to_hold;
    logic   from_hold;

    logic [TAG_WIDTH-1:0] fly_tag;
    logic [C_WIDTH-1:0]   hold_q;
    logic [C_WIDTH-1:0]   hold_r;

    assign slot_free = !res_valid || res_ready;
    assign busy      = !empty || (state != IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue     = 1'b0;
        take_dbz  = 1'b0;
        take_div  = 1'b0;
        to_hold   = 1'b0;
        from_hold = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_b != '0) begin
                        if (div_ready) begin
                            pop       = 1'b1;
                            issue     = 1'b1;
                            state_nxt = WAIT;
                        end
                    end else if (slot_free) begin
                        // Zero divisor completes here; the divider is left alone.
                        pop      = 1'b1;
                        take_dbz = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A done seen before it has dropped belongs to the previous job.
                if (armed && div_done) begin
                    if (slot_free) begin
                        take_div  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        to_hold   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    from_hold = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            div_trigger <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_trigger <= issue;
            if (issue) begin
                armed <= 1'b0;
            end else if ((state == WAIT) && !div_done) begin
                armed <= 1'b1;
            end
        end
    end

    // Operands stay put from one issue to the next so the divider never sees
    // them move while it is working.
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            div_a          <= '0;
            div_b          <= '0;
            div_signed_cal <= 1'b0;
        end else if (issue) begin
            div_a          <= head_a;
            div_b          <= head_b;
            div_signed_cal <= head_signed;
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (issue) begin
            fly_tag <= head_tag;
        end
        if (to_hold) begin
            hold_q <= div_q;
            hold_r <= div_r;
        end
    end

    // ---------------------------------------------------------------- result slot
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_q     <= '0;
            res_r     <= '0;
            res_tag   <= '0;
            res_dbz   <= 1'b0;
        end else begin
            if (take_dbz) begin
                res_q   <= dbz_quotient();
                res_r   <= head_a;
                res_tag <= head_tag;
                res_dbz <= 1'b1;
            end else if (take_div) begin
                res_q   <= div_q;
                res_r   <= div_r;
                res_tag <= fly_tag;
                res_dbz <= 1'b0;
            end else if (from_hold) begin
                res_q   <= hold_q;
                res_r   <= hold_r;
                res_tag <= fly_tag;
                res_dbz <= 1'b0;
            end

            if (take_dbz || take_div || from_hold) begin
                res_valid <= 1'b1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: directed vector table, multi-cycle corner
// sequences (back-to-back, back-pressure/HOLD, stale done, reset mid-job)
// and a randomized phase, all checked against a result scoreboard filled
// from plain division arithmetic. A behavioural divider sits on the
// divider-side ports.
module tb_div_sequencer;
    localparam int CW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          ctl_clk    = 1'b0;
    logic          reset      = 1'b1;
    logic          req_valid  = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_a      = '0;
    logic [CW-1:0] req_b      = '0;
    logic          req_signed = 1'b0;
    logic [TW-1:0] req_tag    = '0;
    logic          res_valid;
    logic          res_ready  = 1'b1;
    logic [CW-1:0] res_q;
    logic [CW-1:0] res_r;
    logic [TW-1:0] res_tag;
    logic          res_dbz;
    logic          busy;
    logic [CW-1:0] div_a;
    logic [CW-1:0] div_b;
    logic          div_signed_cal;
    logic          div_trigger;
    logic          div_ready;
    logic          div_done;
    logic [CW-1:0] div_q;
    logic [CW-1:0] div_r;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.C_WIDTH(CW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .ctl_clk(ctl_clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_r(res_r), .res_tag(res_tag), .res_dbz(res_dbz),
        .busy(busy),
        .div_a(div_a), .div_b(div_b), .div_signed_cal(div_signed_cal),
        .div_trigger(div_trigger), .div_ready(div_ready), .div_done(div_done),
        .div_q(div_q), .div_r(div_r)
    );

    always #5 ctl_clk = ~ctl_clk;

    // Posedges fall at 5+10k, negedges at 10k: $time/10 gives the edge index
    // at a posedge and the cycle number (cycle N+1 follows edge N) at a negedge.

    function automatic void ref_div(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                    input logic s, output logic [CW-1:0] q,
                                    output logic [CW-1:0] r, output logic dbz);
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); dbz = 1'b0;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------ behavioural divider
    logic          m_ready = 1'b1;
    logic          m_done  = 1'b0;
    logic [CW-1:0] m_q = '0, m_r = '0;
    logic [CW-1:0] m_a = '0, m_b = '0;
    logic          m_s = 1'b0;
    logic          m_busy = 1'b0, m_opchg = 1'b0, m_abort = 1'b1;
    int            m_cnt = 0, m_stale = 0;
    int            m_lat_cfg = 3, m_stale_cfg = 0;
    bit            m_rand_lat = 1'b0;
    int            m_done_edge = -1;
    logic [CW-1:0] m_tq, m_tr;
    logic          m_tdbz;

    assign div_ready = m_ready;
    assign div_done  = m_done;
    assign div_q     = m_q;
    assign div_r     = m_r;

    always @(posedge ctl_clk) begin
        if (reset) m_abort <= 1'b1;
        if (div_trigger === 1'b1) begin
            check("one_job_in_flight", m_busy, 1'b0);
            m_a <= div_a; m_b <= div_b; m_s <= div_signed_cal;
            m_busy <= 1'b1; m_ready <= 1'b0; m_opchg <= 1'b0; m_abort <= 1'b0;
            m_cnt <= m_rand_lat ? int'($urandom_range(0, 6)) : m_lat_cfg;
            m_stale <= m_stale_cfg;
            if (m_stale_cfg == 0) m_done <= 1'b0;
        end else if (m_busy) begin
            if (div_a !== m_a || div_b !== m_b || div_signed_cal !== m_s) m_opchg <= 1'b1;
            if (m_stale > 0) begin
                m_stale <= m_stale - 1;
                if (m_stale == 1) m_done <= 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else begin
                ref_div(m_a, m_b, m_s, m_tq, m_tr, m_tdbz);
                m_q <= m_tq; m_r <= m_tr;
                m_done <= 1'b1; m_ready <= 1'b1; m_busy <= 1'b0;
                m_done_edge <= int'($time / 10);
                if (!m_abort && !reset) check("operands_stable_in_wait", m_opchg, 1'b0);
            end
        end
    end

    // ------------------------------------------------ monitor / scoreboard
    typedef struct {
        logic [CW-1:0] q;
        logic [CW-1:0] r;
        logic [TW-1:0] tag;
        logic          dbz;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int            trig_total = 0, trig_cyc_last = -1, rv_rise_cyc = -1, done_cnt = 0;
    bit            prev_trig = 1'b0, prev_rv = 1'b0, stall_prev = 1'b0;
    logic [CW-1:0] sv_q, sv_r, last_q, last_r;
    logic [TW-1:0] sv_tag, last_tag;
    logic          sv_dbz, last_dbz;

    always @(negedge ctl_clk) begin
        if (div_trigger === 1'b1) begin
            trig_total++;
            trig_cyc_last = int'($time / 10);
            check("trigger_single_pulse", prev_trig, 1'b0);
        end
        prev_trig = (div_trigger === 1'b1);
        if (res_valid === 1'b1 && !prev_rv) rv_rise_cyc = int'($time / 10);
        if (stall_prev && res_valid === 1'b1)
            check("res_stable_while_stalled", {res_q, res_r, res_tag, res_dbz},
                  {sv_q, sv_r, sv_tag, sv_dbz});
        if (res_valid === 1'b1 && res_ready && !reset) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got tag %0d q 0x%0h, required no result", res_tag, res_q);
            end else begin
                mon_e = exp_q.pop_front();
                check("order_q", res_q, mon_e.q);
                check("order_r", res_r, mon_e.r);
                check("order_tag", res_tag, mon_e.tag);
                check("order_dbz", res_dbz, mon_e.dbz);
            end
            last_q = res_q; last_r = res_r; last_tag = res_tag; last_dbz = res_dbz;
            done_cnt++;
        end
        stall_prev = (res_valid === 1'b1) && !res_ready && !reset;
        sv_q = res_q; sv_r = res_r; sv_tag = res_tag; sv_dbz = res_dbz;
        prev_rv = (res_valid === 1'b1);
    end

    // ------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic s,
                        input logic [TW-1:0] tag, output int acc);
        int   w = 0;
        exp_t e;
        req_a = a; req_b = b; req_signed = s; req_tag = tag; req_valid = 1'b1;
        while (!req_ready && w < 300) begin tick(); w++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready 0 after %0d cycles, required 1", w);
            req_valid = 1'b0; acc = -1;
            return;
        end
        @(posedge ctl_clk);
        acc = int'($time / 10);
        ref_div(a, b, s, e.q, e.r, e.dbz);
        e.tag = tag;
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int w = 0;
        while (done_cnt < target && w < 400) begin tick(); w++; end
        if (done_cnt < target) begin
            checks++; errors++;
            $display("FAIL result_timeout: results %0d, required %0d", done_cnt, target);
        end
    endtask

    task automatic wait_trig(input int target);
        int w = 0;
        while (trig_total < target && w < 200) begin tick(); w++; end
        if (trig_total < target) begin
            checks++; errors++;
            $display("FAIL trigger_timeout: triggers %0d, required %0d", trig_total, target);
        end
    endtask

    // ------------------------------------------------ stimulus
    typedef struct {
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic          s;
        logic [TW-1:0] tag;
        logic [CW-1:0] q;
        logic [CW-1:0] r;
        logic          dbz;
    } vec_t;
    vec_t vt [8];

    int            acc, t0, d0, t1;
    bit            rand_done;
    logic [CW-1:0] ra, rb;
    logic          rs;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h13579bdf, 32'h00002468, 1'b0, 4'd3,  32'h00008802, 32'h0000130F, 1'b0};
        vt[1] = '{32'h013579bd, 32'h002468ac, 1'b0, 4'd5,  32'h00000008, 32'h0012345D, 1'b0};
        vt[2] = '{32'h00001234, 32'h00000000, 1'b0, 4'd6,  32'hFFFFFFFF, 32'h00001234, 1'b1};
        vt[3] = '{32'h00000005, 32'hFFFFFFFD, 1'b1, 4'd7,  32'hFFFFFFFF, 32'h00000002, 1'b0};
        vt[4] = '{32'd100,      32'd7,        1'b0, 4'd9,  32'd14,       32'd2,        1'b0};
        vt[5] = '{32'hFFFFFFF9, 32'h00000002, 1'b1, 4'd10, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vt[6] = '{32'hFFFFFFF9, 32'h00000002, 1'b0, 4'd11, 32'h7FFFFFFC, 32'h00000001, 1'b0};
        vt[7] = '{32'h80000000, 32'h00000000, 1'b1, 4'd12, 32'hFFFFFFFF, 32'h80000000, 1'b1};

        // Reset state.
        repeat (3) @(posedge ctl_clk);
        @(negedge ctl_clk);
        check("reset_req_ready", req_ready, 1'b0);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_trigger", div_trigger, 1'b0);
        check("reset_res_fields", {res_q, res_r, res_tag, res_dbz}, '0);
        check("reset_div_ops", {div_a, div_b, div_signed_cal}, '0);
        @(posedge ctl_clk);
        #1 reset = 1'b0;
        @(negedge ctl_clk);
        check("req_ready_after_reset", req_ready, 1'b1);
        tick();

        // Directed table, one job at a time with a free result slot.
        for (int i = 0; i < 8; i++) begin
            t0 = trig_total; d0 = done_cnt;
            push(vt[i].a, vt[i].b, vt[i].s, vt[i].tag, acc);
            wait_done(d0 + 1);
            check($sformatf("vec%0d_q", i), last_q, vt[i].q);
            check($sformatf("vec%0d_r", i), last_r, vt[i].r);
            check($sformatf("vec%0d_tag", i), last_tag, vt[i].tag);
            check($sformatf("vec%0d_dbz", i), last_dbz, vt[i].dbz);
            if (vt[i].dbz) begin
                check($sformatf("vec%0d_no_trigger", i), trig_total, t0);
                check($sformatf("vec%0d_dbz_latency", i), rv_rise_cyc, acc + 2);
            end else begin
                check($sformatf("vec%0d_one_trigger", i), trig_total, t0 + 1);
                check($sformatf("vec%0d_issue_latency", i), trig_cyc_last, acc + 2);
                check($sformatf("vec%0d_done_to_valid", i), rv_rise_cyc, m_done_edge + 2);
            end
            repeat (2) tick();
        end

        // Back-to-back pushes: results in order.
        d0 = done_cnt; t0 = trig_total;
        push(vt[0].a, vt[0].b, vt[0].s, vt[0].tag, acc);
        push(vt[1].a, vt[1].b, vt[1].s, vt[1].tag, acc);
        wait_done(d0 + 2);
        check("b2b_last_tag", last_tag, 4'd5);
        check("b2b_last_r", last_r, 32'h0012345D);
        check("b2b_triggers", trig_total, t0 + 2);
        repeat (2) tick();

        // Stale done held high across the next trigger.
        m_stale_cfg = 4;
        d0 = done_cnt;
        push(32'd5, 32'hFFFFFFFD, 1'b1, 4'd2, acc);
        wait_done(d0 + 1);
        check("stale_q", last_q, 32'hFFFFFFFF);
        check("stale_r", last_r, 32'd2);
        check("stale_done_to_valid", rv_rise_cyc, m_done_edge + 2);
        m_stale_cfg = 0;
        repeat (2) tick();

        // Back-pressure: FIFO fills, second completion parks in HOLD.
        res_ready = 1'b0;
        d0 = done_cnt; t0 = trig_total;
        for (int k = 0; k < DEPTH + 2; k++)
            push($urandom, 32'($urandom_range(1, 1000)), 1'($urandom_range(0, 1)), 4'(k), acc);
        repeat (20) tick();
        check("full_req_ready", req_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        check("hold_no_third_issue", trig_total, t0 + 2);
        check("hold_res_valid", res_valid, 1'b1);
        check("hold_nothing_taken", done_cnt, d0);
        res_ready = 1'b1;
        wait_done(d0 + DEPTH + 2);
        repeat (3) tick();
        check("drained_busy", busy, 1'b0);
        check("drained_req_ready", req_ready, 1'b1);

        // Reset while a job is in WAIT.
        m_lat_cfg = 20;
        d0 = done_cnt; t0 = trig_total;
        push(vt[4].a, vt[4].b, vt[4].s, vt[4].tag, acc);
        wait_trig(t0 + 1);
        repeat (3) tick();
        reset = 1'b1;
        @(negedge ctl_clk);
        check("midreset_req_ready", req_ready, 1'b0);
        @(posedge ctl_clk);
        #1 reset = 1'b0;
        exp_q.delete();
        m_lat_cfg = 3;
        @(negedge ctl_clk);
        check("midreset_res_valid", res_valid, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_trigger", div_trigger, 1'b0);
        check("midreset_div_ops", {div_a, div_b, div_signed_cal}, '0);
        tick();
        t1 = trig_total;
        push(vt[6].a, vt[6].b, vt[6].s, vt[6].tag, acc);
        wait_trig(t1 + 1);
        check("midreset_issue_after_ready", trig_cyc_last, m_done_edge + 2);
        check("midreset_no_late_result", done_cnt, d0);
        wait_done(d0 + 1);
        check("midreset_next_tag", last_tag, vt[6].tag);
        check("midreset_next_q", last_q, vt[6].q);
        repeat (2) tick();

        // Randomized jobs with random consumer back-pressure and latency.
        m_rand_lat = 1'b1;
        d0 = done_cnt;
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    ra = $urandom;
                    case ($urandom_range(0, 7))
                        0:       rb = '0;
                        1:       rb = 32'($urandom_range(1, 15));
                        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
                        default: rb = $urandom;
                    endcase
                    rs = 1'($urandom_range(0, 1));
                    if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
                    push(ra, rb, rs, 4'($urandom_range(0, 15)), acc);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        res_ready = 1'b1;
        wait_done(d0 + 40);
        repeat (5) tick();
        check("random_all_returned", done_cnt, d0 + 40);
        check("random_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
